tt_um_jk2102_ppt: RTL and testbench

//  Programmable pulse-train (PPT) controller for a TinyTapeout tile, clocked at 32.768 kHz.
//  An I2C slave (7-bit addr 0x5A) sets period, width and pulse count, starts and stops the train,
//  and reads back progress. Output pulses appear on uo_out[0].

---
 rtl/jk2102_pkg.sv | 31 +++
 rtl/jk2102_if.sv | 9 +
 rtl/jk2102_i2c_slave.sv | 163 ++++++++++++++++
 rtl/tt_um_jk2102_ppt.sv | 141 ++++++++++++++
 tb/tb_tt_um_jk2102_ppt.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jk2102_pkg.sv
// Shared constants, register map and I2C FSM state type for the jk2102 pulse-train tile.
package jk2102_pkg;

  localparam logic [6:0] I2C_ADDR = 7'h5A;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [7:0] REG_PERIOD_H = 8'h00;
  localparam logic [7:0] REG_PERIOD_L = 8'h01;
  localparam logic [7:0] REG_WIDTH_H  = 8'h02;
  localparam logic [7:0] REG_WIDTH_L  = 8'h03;
  localparam logic [7:0] REG_COUNT_H  = 8'h04;
  localparam logic [7:0] REG_COUNT_L  = 8'h05;
  localparam logic [7:0] REG_RUN      = 8'h07;
  localparam logic [7:0] REG_CDONE_H  = 8'h08;
  localparam logic [7:0] REG_CDONE_L  = 8'h09;
  localparam logic [7:0] REG_DONE     = 8'h0A;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } i2c_state_e;

endpackage

// File: rtl/jk2102_if.sv
// I2C pin bundle: resolved SCL/SDA levels plus the slave's open-drain pull request.
interface jk2102_if;
  logic scl;
  logic sda;
  logic sda_pull;

  modport master (output scl, output sda, input sda_pull);
  modport slave  (input scl, input sda, output sda_pull);
endinterface

// File: rtl/jk2102_i2c_slave.sv
// I2C slave: pin synchronizers, START/STOP detection, byte FSM and open-drain SDA drive.
module jk2102_i2c_slave
  import jk2102_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  jk2102_if.slave    bus,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d, data_q, data_d;
  logic       rw_q, rw_d, sda_pull_q, sda_pull_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '0;
      sda_sync_q <= '0;
      scl_prev_q <= 1'b0;
      sda_prev_q <= 1'b0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      sda_pull_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl};
      sda_sync_q <= {sda_sync_q[0], bus.sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      sda_pull_q <= sda_pull_d;
    end
  end

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;
  assign byte_in   = {shift_q[6:0], sda};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    rw_d       = rw_q;
    sda_pull_d = sda_pull_q;
    wr_en      = 1'b0;
    if (!ena) begin
      state_d    = StIdle;
      sda_pull_d = 1'b0;
    end else if (start_det) begin
      state_d    = StAddr;
      bit_cnt_d  = '0;
      sda_pull_d = 1'b0;
    end else if (stop_det) begin
      state_d    = StIdle;
      sda_pull_d = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        StAddr: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d    = byte_in[0];
            state_d = (byte_in[7:1] == I2C_ADDR) ? StAddrAck : StIdle;
          end
        end
        StAddrAck: begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d = StRdata;
            tx_d    = rd_data;
          end else begin
            state_d = StPtr;
          end
        end
        StPtr: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = byte_in;
            state_d = StPtrAck;
          end
        end
        StPtrAck: begin
          bit_cnt_d = '0;
          state_d   = StWdata;
        end
        StWdata: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d  = byte_in;
            state_d = StWdataAck;
          end
        end
        StWdataAck: begin
          wr_en     = 1'b1;
          ptr_d     = ptr_q + 8'd1;
          bit_cnt_d = '0;
          state_d   = StWdata;
        end
        StRdata: begin
          tx_d      = {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = ptr_q + 8'd1;
            state_d = StRdataAck;
          end
        end
        StRdataAck: begin
          bit_cnt_d = '0;
          if (!sda) begin
            state_d = StRdata;
            tx_d    = rd_data;
          end else begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // SDA only moves while SCL is low, so all drive changes happen on the falling edge.
      case (state_q)
        StAddrAck, StPtrAck, StWdataAck: sda_pull_d = 1'b1;
        StRdata:                         sda_pull_d = ~tx_q[7];
        default:                         sda_pull_d = 1'b0;
      endcase
    end
  end

  assign wr_addr      = ptr_q;
  assign wr_data      = data_q;
  assign rd_addr      = ptr_q;
  assign bus.sda_pull = sda_pull_q & ena;

endmodule

// File: rtl/tt_um_jk2102_ppt.sv
// Programmable pulse-train tile: I2C register file plus pulse engine driving uo_out.
// Define JK2102_STATUS_OUT_EN to expose COUNT_DONE[4:0] on uo_out[7:3].
module tt_um_jk2102_ppt
  import jk2102_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic             wr_en, run_wr;
  logic [7:0]       wr_addr, wr_data, rd_addr, rd_data;
  logic [CNT_W-1:0] period_q, period_d, width_q, width_d, count_q, count_d;
  logic [CNT_W-1:0] ph_q, ph_d, cdone_q, cdone_d;
  logic             run_q, run_d, done_q, done_d, pulse_q, pulse_d, running_q, running_d;
  logic [4:0]       status;
  logic             unused_ok;

  jk2102_if i2c_bus ();
  assign i2c_bus.scl = uio_in[0];
  assign i2c_bus.sda = uio_in[1];

  jk2102_i2c_slave u_i2c (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .bus     (i2c_bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      width_q   <= '0;
      count_q   <= '0;
      run_q     <= 1'b0;
      ph_q      <= '0;
      cdone_q   <= '0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      width_q   <= width_d;
      count_q   <= count_d;
      run_q     <= run_d;
      ph_q      <= ph_d;
      cdone_q   <= cdone_d;
      done_q    <= done_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    period_d  = period_q;
    width_d   = width_q;
    count_d   = count_q;
    run_d     = run_q;
    run_wr    = 1'b0;
    ph_d      = ph_q;
    cdone_d   = cdone_q;
    done_d    = done_q;
    pulse_d   = pulse_q;
    running_d = running_q;
    if (ena) begin
      if (wr_en) begin
        case (wr_addr)
          REG_PERIOD_H: period_d[15:8] = wr_data;
          REG_PERIOD_L: period_d[7:0]  = wr_data;
          REG_WIDTH_H:  width_d[15:8]  = wr_data;
          REG_WIDTH_L:  width_d[7:0]   = wr_data;
          REG_COUNT_H:  count_d[15:8]  = wr_data;
          REG_COUNT_L:  count_d[7:0]   = wr_data;
          REG_RUN: begin
            run_d  = wr_data[0];
            run_wr = 1'b1;
          end
          default: ;
        endcase
      end
      // A RUN write restarts the train and wins over a coincident period wrap.
      if (run_wr) begin
        ph_d    = '0;
        cdone_d = '0;
        done_d  = 1'b0;
      end else if (run_q && period_q == '0) begin
        done_d = 1'b0;
      end else if (run_q && !done_q) begin
        // >= also catches a phase stranded above a freshly shortened period.
        if (ph_q >= period_q - CNT_ONE) begin
          ph_d    = '0;
          cdone_d = cdone_q + CNT_ONE;
          if (count_d != '0 && cdone_d == count_d) done_d = 1'b1;
        end else begin
          ph_d = ph_q + CNT_ONE;
        end
      end
      running_d = run_d && (period_d != '0) && !done_d;
      pulse_d   = running_d && (ph_d < width_d);
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_PERIOD_H: rd_data = period_q[15:8];
      REG_PERIOD_L: rd_data = period_q[7:0];
      REG_WIDTH_H:  rd_data = width_q[15:8];
      REG_WIDTH_L:  rd_data = width_q[7:0];
      REG_COUNT_H:  rd_data = count_q[15:8];
      REG_COUNT_L:  rd_data = count_q[7:0];
      REG_RUN:      rd_data = {7'b0, run_q};
      REG_CDONE_H:  rd_data = cdone_q[15:8];
      REG_CDONE_L:  rd_data = cdone_q[7:0];
      REG_DONE:     rd_data = {7'b0, done_q};
      default:      rd_data = '0;
    endcase
  end

`ifdef JK2102_STATUS_OUT_EN
  assign status = cdone_q[4:0];
`else
  assign status = '0;
`endif

  assign uo_out    = {status, running_q, done_q, pulse_q};
  assign uio_out   = '0;
  assign uio_oe    = {6'b0, i2c_bus.sda_pull, 1'b0};
  assign unused_ok = ^{ui_in, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_jk2102_ppt.sv
// Directed bench: bit-banged I2C host, hand-computed expectations for the pulse-train tile.
module tb_tt_um_jk2102_ppt;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       scl_drv, sda_drv, arm;
  int         n_vec, n_err;
  int         oe_total = 0;
  int         cur_len = 0;
  int         first_len = 0;
  bit         got_first = 1'b0;

  jk2102_if host ();
  assign host.scl      = scl_drv;
  assign host.sda_pull = uio_oe[1];
  assign host.sda      = sda_drv & ~host.sda_pull;
  assign uio_in        = {6'b0, host.sda, host.scl};

  tt_um_jk2102_ppt dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) oe_total <= oe_total + ((uio_oe != 8'h00) ? 1 : 0);

  // Length of the first high pulse seen after arm goes high.
  always @(negedge clk) begin
    if (!arm) begin
      cur_len   <= 0;
      first_len <= 0;
      got_first <= 1'b0;
    end else if (!got_first) begin
      if (uo_out[0]) cur_len <= cur_len + 1;
      else if (cur_len > 0) begin
        first_len <= cur_len;
        got_first <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; w(3);
    scl_drv = 1'b1; w(6);
    sda_drv = 1'b0; w(6);
    scl_drv = 1'b0; w(3);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; w(3);
    scl_drv = 1'b1; w(6);
    sda_drv = 1'b1; w(6);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_drv = b; w(3);
    scl_drv = 1'b1; w(3);
    r = host.sda; w(3);
    scl_drv = 1'b0; w(3);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(~ack, r);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    logic k0, k1, k2;
    i2c_start();
    write_byte(8'hB4, k0);
    write_byte(a, k1);
    write_byte(d, k2);
    i2c_stop();
    check("wr_ack", {29'b0, k0, k1, k2}, 32'h7);
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic       k0, k1, k2;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hB4, k0);
    write_byte(a, k1);
    i2c_start();
    write_byte(8'hB5, k2);
    read_byte(1'b0, d);
    i2c_stop();
    check("rd_ack", {29'b0, k0, k1, k2}, 32'h7);
    check(tag, {24'b0, d}, {24'b0, exp});
  endtask

  initial begin
    logic       k0, k1, k2;
    logic [4:0] exp_status;
    int         cnt, oe0;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
    scl_drv = 1'b1; sda_drv = 1'b1; arm = 1'b0;
`ifdef JK2102_STATUS_OUT_EN
    exp_status = 5'd18;
`else
    exp_status = 5'd0;
`endif
    w(3);
    check("rst_uo_out", {24'b0, uo_out}, 32'h0);
    check("rst_uio_oe", {24'b0, uio_oe}, 32'h0);
    check("rst_uio_out", {24'b0, uio_out}, 32'h0);
    rst_n = 1'b1; w(5);
    read_check("rst_period_l", 8'h01, 8'h00);

    // Period 32, width 4, 50 periods.
    reg_write(8'h07, 8'h00);
    reg_write(8'h01, 8'd32);
    reg_write(8'h03, 8'd4);
    reg_write(8'h05, 8'd50);
    arm = 1'b1;
    reg_write(8'h07, 8'h01);
    w(40);
    check("first_pulse_len", first_len, 4);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      w(1);
      if (uo_out[0]) cnt++;
    end
    check("duty_64cyc", cnt, 8);
    check("running", {31'b0, uo_out[2]}, 1);

    for (int i = 0; i < 3000 && !uo_out[1]; i++) w(1);
    check("done_set", {31'b0, uo_out[1]}, 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      w(1);
      if (uo_out[0]) cnt++;
    end
    check("pulse_after_done", cnt, 0);
    check("running_after_done", {31'b0, uo_out[2]}, 0);
    check("status_bits", {27'b0, uo_out[7:3]}, {27'b0, exp_status});
    read_check("cdone_h", 8'h08, 8'h00);
    read_check("cdone_l", 8'h09, 8'h32);
    read_check("done_reg", 8'h0A, 8'h01);
    read_check("reserved_reg", 8'h06, 8'h00);
    read_check("unmapped_reg", 8'h20, 8'h00);

    // Foreign address: NACK, SDA never driven, trailing bytes ignored.
    oe0 = oe_total;
    i2c_start();
    write_byte(8'h78, k0);
    write_byte(8'h01, k1);
    write_byte(8'h55, k2);
    i2c_stop();
    check("nack_addr", {31'b0, k0}, 0);
    check("nack_oe_cycles", oe_total - oe0, 0);
    read_check("period_l_kept", 8'h01, 8'h20);
    read_check("count_l_kept", 8'h05, 8'h32);

    // Stop mid-run and restart.
    reg_write(8'h07, 8'h00);
    check("done_clr", {31'b0, uo_out[1]}, 0);
    reg_write(8'h07, 8'h01);
    w(200);
    check("running_mid", {31'b0, uo_out[2]}, 1);
    reg_write(8'h07, 8'h00);
    check("pulse_stop", {31'b0, uo_out[0]}, 0);
    check("running_stop", {31'b0, uo_out[2]}, 0);
    read_check("cdone_clr", 8'h09, 8'h00);
    arm = 1'b0; w(2);
    arm = 1'b1;
    reg_write(8'h07, 8'h01);
    w(40);
    check("restart_pulse_len", first_len, 4);

    // Width beyond period, continuous: held high, DONE never sets across a COUNT_DONE wrap.
    reg_write(8'h07, 8'h00);
    reg_write(8'h03, 8'd40);
    reg_write(8'h05, 8'h00);
    reg_write(8'h07, 8'h01);
    w(5);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      w(1);
      if (!uo_out[0]) cnt++;
    end
    check("wide_pulse_held", cnt, 0);
    reg_write(8'h01, 8'd1);
    cnt = 0;
    for (int i = 0; i < 65600; i++) begin
      w(1);
      if (!uo_out[0] || uo_out[1]) cnt++;
    end
    check("wide_long_run", cnt, 0);
    check("running_long", {31'b0, uo_out[2]}, 1);
    read_check("done_never", 8'h0A, 8'h00);

    // Reset while the slave pulls SDA low for a 0 data bit (PERIOD_H = 0).
    i2c_start();
    write_byte(8'hB4, k0);
    write_byte(8'h00, k1);
    i2c_start();
    write_byte(8'hB5, k2);
    check("rst_read_ack", {29'b0, k0, k1, k2}, 32'h7);
    w(2);
    check("oe_mid_read", {31'b0, uio_oe[1]}, 1);
    #1 rst_n = 1'b0;
    #1 check("oe_in_reset", {24'b0, uio_oe}, 32'h0);
    check("uo_in_reset", {24'b0, uo_out}, 32'h0);
    w(3);
    scl_drv = 1'b1; w(3);
    sda_drv = 1'b1; w(3);
    rst_n = 1'b1; w(5);
    read_check("period_l_after_rst", 8'h01, 8'h00);
    read_check("width_l_after_rst", 8'h03, 8'h00);
    read_check("run_after_rst", 8'h07, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
